// File: rtl/mips_dbg_pkg.sv
// rtl/mips_dbg_pkg.sv - shared types and defaults for the core run controller
package mips_dbg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESET = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } run_state_e;

  localparam int          PC_W_DEF    = 16;
  localparam logic [15:0] HALT_PC_DEF = 16'hFFFC;

endpackage

// File: rtl/pc_trace_buf.sv
// rtl/pc_trace_buf.sv - circular PC history with newest-first read mux
module pc_trace_buf #(
  parameter int PC_W  = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic [PC_W-1:0]          din,
  input  logic [$clog2(DEPTH)-1:0] idx,
  output logic [PC_W-1:0]          dout,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [PC_W-1:0]  mem_q [DEPTH];
  logic [IDX_W-1:0] wptr_q;
  logic [IDX_W:0]   count_q;
  logic [IDX_W-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else if (push) begin
      mem_q[wptr_q] <= din;
      wptr_q        <= wptr_q + 1'b1;
      if (count_q != (IDX_W+1)'(DEPTH)) count_q <= count_q + 1'b1;
    end
  end

  // DEPTH is a power of two, so the pointer arithmetic wraps for free
  always_comb begin
    rd_ptr = wptr_q - 1'b1 - idx;
    dout   = ({1'b0, idx} < count_q) ? mem_q[rd_ptr] : '0;
  end

  assign count = count_q;

endmodule

// File: rtl/mips_run_ctrl.sv
// rtl/mips_run_ctrl.sv - start/reset-hold/run sequencer for the single_cycle core
module mips_run_ctrl
  import mips_dbg_pkg::*;
#(
  parameter int              PC_W        = PC_W_DEF,
  parameter int              RST_CYCLES  = 4,
  parameter logic [PC_W-1:0] HALT_PC     = PC_W'(HALT_PC_DEF),
  parameter int              STALL_LIMIT = 3,
  parameter int              MAX_CYCLES  = 1000,
  parameter int              TRACE_DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           abort,
  input  logic [PC_W-1:0]                pc,
  output logic                           core_rst,
  output logic                           busy,
  output logic                           done,
  output logic                           timeout,
  output logic [15:0]                    cycle_cnt,
  input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
  output logic [PC_W-1:0]                trace_pc,
  output logic [$clog2(TRACE_DEPTH):0]   trace_cnt
);

  localparam int RC_W = $clog2(RST_CYCLES + 1);
  localparam int SC_W = $clog2(STALL_LIMIT + 1);

  run_state_e      state_q, state_d;
  logic [RC_W-1:0] rst_cnt_q, rst_cnt_d;
  logic [SC_W-1:0] stall_q, stall_d;
  logic            have_prev_q, have_prev_d;
  logic [PC_W-1:0] prev_pc_q, prev_pc_d;
  logic [15:0]     cycle_q, cycle_d;
  logic            tmo_q, tmo_d;
  logic            core_rst_q, core_rst_d, busy_q, busy_d, done_q, done_d;
  logic            trace_clr, trace_push;
  logic            hit_halt, hit_loop, hit_budget;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rst_cnt_q   <= '0;
      stall_q     <= '0;
      have_prev_q <= 1'b0;
      prev_pc_q   <= '0;
      cycle_q     <= '0;
      tmo_q       <= 1'b0;
      core_rst_q  <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      stall_q     <= stall_d;
      have_prev_q <= have_prev_d;
      prev_pc_q   <= prev_pc_d;
      cycle_q     <= cycle_d;
      tmo_q       <= tmo_d;
      core_rst_q  <= core_rst_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    stall_d     = stall_q;
    have_prev_d = have_prev_q;
    prev_pc_d   = prev_pc_q;
    cycle_d     = cycle_q;
    tmo_d       = tmo_q;
    trace_clr   = 1'b0;
    trace_push  = 1'b0;
    hit_halt    = 1'b0;
    hit_loop    = 1'b0;
    hit_budget  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d     = ST_RESET;
          trace_clr   = 1'b1;
          rst_cnt_d   = '0;
          stall_d     = '0;
          have_prev_d = 1'b0;
          cycle_d     = '0;
          tmo_d       = 1'b0;
        end
      end
      ST_RESET: begin
        if (abort) state_d = ST_IDLE;
        else if (rst_cnt_q == RC_W'(RST_CYCLES - 1)) state_d = ST_RUN;
        else rst_cnt_d = rst_cnt_q + 1'b1;
      end
      ST_RUN: begin
        // every RUN cycle is a sample, even the one in which abort arrives
        trace_push  = 1'b1;
        cycle_d     = cycle_q + 16'd1;
        prev_pc_d   = pc;
        have_prev_d = 1'b1;
        stall_d     = (have_prev_q && pc == prev_pc_q) ? stall_q + 1'b1 : '0;
        hit_halt    = (pc == HALT_PC);
        hit_loop    = (stall_d == SC_W'(STALL_LIMIT));
        hit_budget  = (cycle_d == 16'(MAX_CYCLES));
        if (abort) begin
          state_d = ST_IDLE;
        end else if (hit_halt || hit_loop || hit_budget) begin
          state_d = ST_DONE;
          tmo_d   = !(hit_halt || hit_loop);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    core_rst_d = (state_d != ST_RUN);
    busy_d     = (state_d == ST_RESET) || (state_d == ST_RUN);
    done_d     = (state_d == ST_DONE);
  end

  pc_trace_buf #(
    .PC_W  (PC_W),
    .DEPTH (TRACE_DEPTH)
  ) u_trace (
    .clk   (clk),
    .rst   (rst),
    .clr   (trace_clr),
    .push  (trace_push),
    .din   (pc),
    .idx   (trace_idx),
    .dout  (trace_pc),
    .count (trace_cnt)
  );

  assign core_rst  = core_rst_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign timeout   = tmo_q;
  assign cycle_cnt = cycle_q;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// tb/tb_mips_run_ctrl.sv - randomized self-checking bench for mips_run_ctrl
module tb_mips_run_ctrl;

  localparam int          RSTC  = 2;
  localparam int          STALL = 3;
  localparam int          MAXC  = 10;
  localparam int          TD    = 8;
  localparam logic [15:0] HALT  = 16'h0010;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [15:0] pc;
  logic [2:0]  trace_idx;
  logic        core_rst, busy, done, timeout;
  logic [15:0] cycle_cnt, trace_pc;
  logic [3:0]  trace_cnt;

  int total = 0;
  int bad   = 0;
  logic [15:0] pcs[$];

  mips_run_ctrl #(
    .PC_W(16), .RST_CYCLES(RSTC), .HALT_PC(HALT), .STALL_LIMIT(STALL),
    .MAX_CYCLES(MAXC), .TRACE_DEPTH(TD)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .pc(pc),
    .core_rst(core_rst), .busy(busy), .done(done), .timeout(timeout),
    .cycle_cnt(cycle_cnt), .trace_idx(trace_idx), .trace_pc(trace_pc),
    .trace_cnt(trace_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run length from the rules: first halt PC, first window of STALL+1 equal
  // samples, or the budget, whichever sample index comes first.
  function automatic int model_len(output bit tmo);
    bit loop;
    for (int i = 0; i < pcs.size(); i++) begin
      loop = (i >= STALL);
      for (int j = 1; j <= STALL; j++)
        if (loop && pcs[i-j] != pcs[i]) loop = 1'b0;
      if (pcs[i] == HALT || loop) begin tmo = 1'b0; return i + 1; end
      if (i + 1 == MAXC) begin tmo = 1'b1; return i + 1; end
    end
    tmo = 1'b0;
    return -1;
  endfunction

  function automatic logic [15:0] model_trace(input int n, input int idx);
    if (idx >= n || idx >= TD) return 16'h0;
    return pcs[n-1-idx];
  endfunction

  // Pulses start, then feeds pcs[k] on every RUN cycle until the DUT leaves busy.
  task automatic run_seq(input int abort_at, input int restart_at, output int hold);
    int k;
    int guard;
    k = 0; guard = 0; hold = 0;
    start = 1'b1; tick(); start = 1'b0;
    while (busy === 1'b1 && guard < 200) begin
      guard++;
      if (core_rst) hold++;
      else begin
        pc = (k < pcs.size()) ? pcs[k] : 16'h0;
        if (k == abort_at)   abort = 1'b1;
        if (k == restart_at) start = 1'b1;
        k++;
      end
      tick();
      abort = 1'b0;
      start = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; pc = 16'h0; trace_idx = 3'd0;
    tick(); tick();
    total++;
    if ({core_rst, busy, done, timeout} !== 4'b1000) begin
      bad++; $display("FAIL reset_flags got %b want 1000", {core_rst, busy, done, timeout});
    end
    total++;
    if (cycle_cnt !== 16'd0 || trace_cnt !== 4'd0) begin
      bad++; $display("FAIL reset_counts got cyc=%0d tcnt=%0d want 0 0", cycle_cnt, trace_cnt);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_halt();
    int hold;
    pcs = '{16'h0, 16'h4, 16'h8, 16'hC, 16'h10, 16'h14, 16'h18, 16'h1C, 16'h20, 16'h24};
    run_seq(-1, -1, hold);
    total++;
    if (hold !== RSTC) begin bad++; $display("FAIL halt_hold got %0d want %0d", hold, RSTC); end
    total++;
    if ({done, timeout, core_rst, busy} !== 4'b1010) begin
      bad++; $display("FAIL halt_flags got %b want 1010", {done, timeout, core_rst, busy});
    end
    total++;
    if (cycle_cnt !== 16'd5) begin bad++; $display("FAIL halt_cycles got %0d want 5", cycle_cnt); end
    trace_idx = 3'd0; #1;
    total++;
    if (trace_pc !== 16'h10) begin bad++; $display("FAIL halt_trace0 got %h want 0010", trace_pc); end
    trace_idx = 3'd4; #1;
    total++;
    if (trace_pc !== 16'h0) begin bad++; $display("FAIL halt_trace4 got %h want 0000", trace_pc); end
    trace_idx = 3'd5; #1;
    total++;
    if (trace_pc !== 16'h0) begin bad++; $display("FAIL halt_trace5 got %h want 0000", trace_pc); end
  endtask

  task automatic test_self_loop();
    int hold;
    pcs = '{16'h0, 16'h4, 16'h8, 16'h8, 16'h8, 16'h8, 16'h8, 16'h8, 16'h8, 16'h8};
    run_seq(-1, -1, hold);
    total++;
    if ({done, timeout} !== 2'b10 || cycle_cnt !== 16'd6) begin
      bad++; $display("FAIL loop_end got done=%b tmo=%b cyc=%0d want 1 0 6", done, timeout, cycle_cnt);
    end
  endtask

  task automatic test_timeout();
    int hold;
    logic [15:0] v;
    logic [15:0] exp;
    pcs.delete();
    v = 16'h0;
    for (int i = 0; i < 12; i++) begin
      if (v == HALT) v = v + 16'd4;
      pcs.push_back(v);
      v = v + 16'd4;
    end
    run_seq(-1, -1, hold);
    total++;
    if ({done, timeout} !== 2'b11 || cycle_cnt !== 16'd10) begin
      bad++; $display("FAIL tmo_end got done=%b tmo=%b cyc=%0d want 1 1 10", done, timeout, cycle_cnt);
    end
    total++;
    if (trace_cnt !== 4'd8) begin bad++; $display("FAIL tmo_tcnt got %0d want 8", trace_cnt); end
    for (int i = 0; i < TD; i++) begin
      trace_idx = 3'(i); #1;
      exp = pcs[9-i];
      total++;
      if (trace_pc !== exp) begin bad++; $display("FAIL tmo_trace%0d got %h want %h", i, trace_pc, exp); end
    end
  endtask

  task automatic test_abort();
    int hold;
    pcs = '{16'h40, 16'h44, 16'h48, 16'h4C, 16'h50, 16'h54, 16'h58, 16'h5C, 16'h60, 16'h64};
    run_seq(2, 1, hold);
    total++;
    if ({busy, done, core_rst} !== 3'b001 || cycle_cnt !== 16'd3) begin
      bad++; $display("FAIL abort_end got b/d/r=%b cyc=%0d want 001 3", {busy, done, core_rst}, cycle_cnt);
    end
    trace_idx = 3'd0; #1;
    total++;
    if (trace_pc !== 16'h48 || trace_cnt !== 4'd3) begin
      bad++; $display("FAIL abort_trace got %h/%0d want 0048/3", trace_pc, trace_cnt);
    end
    abort = 1'b1; tick(); abort = 1'b0;
    total++;
    if (busy !== 1'b0 || cycle_cnt !== 16'd3) begin
      bad++; $display("FAIL abort_idle got busy=%b cyc=%0d want 0 3", busy, cycle_cnt);
    end
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0;
    total++;
    if (busy !== 1'b1 || cycle_cnt !== 16'd0) begin
      bad++; $display("FAIL start_wins got busy=%b cyc=%0d want 1 0", busy, cycle_cnt);
    end
    tick(); abort = 1'b0;
    total++;
    if (busy !== 1'b0 || core_rst !== 1'b1) begin
      bad++; $display("FAIL abort_reset got busy=%b rst=%b want 0 1", busy, core_rst);
    end
  endtask

  task automatic test_priority_rerun();
    int hold;
    int guard;
    pcs = '{16'h100, 16'h104, 16'h108, 16'h10C, 16'h110, 16'h114, 16'h118, 16'h11C, 16'h120, HALT, 16'h0};
    run_seq(-1, -1, hold);
    total++;
    if ({done, timeout} !== 2'b10 || cycle_cnt !== 16'd10) begin
      bad++; $display("FAIL prio_end got done=%b tmo=%b cyc=%0d want 1 0 10", done, timeout, cycle_cnt);
    end
    start = 1'b1; tick(); start = 1'b0;
    total++;
    if ({busy, done, timeout} !== 3'b100 || cycle_cnt !== 16'd0 || trace_cnt !== 4'd0) begin
      bad++; $display("FAIL rerun_clear got b/d/t=%b cyc=%0d tcnt=%0d want 100 0 0",
                      {busy, done, timeout}, cycle_cnt, trace_cnt);
    end
    guard = 0;
    while (core_rst === 1'b1 && guard < 20) begin guard++; tick(); end
    pc = 16'h200; tick(); pc = 16'h204; tick();
    total++;
    if (cycle_cnt !== 16'd2 || busy !== 1'b1) begin
      bad++; $display("FAIL rerun_run got cyc=%0d busy=%b want 2 1", cycle_cnt, busy);
    end
    rst = 1'b1; tick();
    total++;
    if ({core_rst, busy, done, timeout} !== 4'b1000 || cycle_cnt !== 16'd0 || trace_cnt !== 4'd0) begin
      bad++; $display("FAIL midrun_rst got flags=%b cyc=%0d tcnt=%0d want 1000 0 0",
                      {core_rst, busy, done, timeout}, cycle_cnt, trace_cnt);
    end
    rst = 1'b0; tick();
  endtask

  task automatic test_random();
    int hold, n, r;
    bit tmo;
    logic [15:0] v;
    logic [15:0] exp;
    for (int it = 0; it < 25; it++) begin
      pcs.delete();
      v = 16'($urandom_range(0, 7) * 4);
      for (int i = 0; i < 12; i++) begin
        r = $urandom_range(0, 9);
        if (r < 6)       v = v + 16'd4;
        else if (r == 8) v = 16'($urandom_range(0, 15) * 4);
        else if (r == 9) v = HALT;
        pcs.push_back(v);
      end
      n = model_len(tmo);
      run_seq(-1, -1, hold);
      total++;
      if (done !== 1'b1 || timeout !== tmo || cycle_cnt !== 16'(n)) begin
        bad++; $display("FAIL rnd%0d_end got done=%b tmo=%b cyc=%0d want 1 %b %0d",
                        it, done, timeout, cycle_cnt, tmo, n);
      end
      total++;
      if (trace_cnt !== 4'((n < TD) ? n : TD)) begin
        bad++; $display("FAIL rnd%0d_tcnt got %0d want %0d", it, trace_cnt, (n < TD) ? n : TD);
      end
      for (int i = 0; i < TD; i++) begin
        trace_idx = 3'(i); #1;
        exp = model_trace(n, i);
        total++;
        if (trace_pc !== exp) begin
          bad++; $display("FAIL rnd%0d_trace%0d got %h want %h", it, i, trace_pc, exp);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_halt();
    test_self_loop();
    test_timeout();
    test_abort();
    test_priority_rerun();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
